// File: rtl/low_priority_encoder_4_2_if.sv
// low_priority_encoder_4_2_if: request/code bus for the 4:2 low-index priority encoder; Valid_Out exists only with LPE_VALID_OUT_EN
interface low_priority_encoder_4_2_if;
  logic       Enable_In;
  logic       Data_0_In;
  logic       Data_1_In;
  logic       Data_2_In;
  logic       Data_3_In;
  wire  [1:0] Encoded_Value_Out;
`ifdef LPE_VALID_OUT_EN
  logic       Valid_Out;
  modport master (
    output Enable_In, Data_0_In, Data_1_In, Data_2_In, Data_3_In,
    input  Encoded_Value_Out, Valid_Out
  );
  modport slave (
    input  Enable_In, Data_0_In, Data_1_In, Data_2_In, Data_3_In,
    output Encoded_Value_Out, Valid_Out
  );
`else
  modport master (
    output Enable_In, Data_0_In, Data_1_In, Data_2_In, Data_3_In,
    input  Encoded_Value_Out
  );
  modport slave (
    input  Enable_In, Data_0_In, Data_1_In, Data_2_In, Data_3_In,
    output Encoded_Value_Out
  );
`endif
endinterface

// File: rtl/low_priority_encoder_4_2.sv
// low_priority_encoder_4_2: registered 4:2 encoder, Data_0_In wins, code = 3 - index, tri-stated when invalid; LPE_VALID_OUT_EN adds Valid_Out
module low_priority_encoder_4_2 (
  input logic                        Clock_In,
  input logic                        Reset_In,
  low_priority_encoder_4_2_if.slave  bus
);
  logic [1:0] encoded_value_q, encoded_value_d, code;
  logic       valid_q, valid_d;
  always_comb begin
    code = bus.Data_0_In ? 2'd3 : bus.Data_1_In ? 2'd2 : bus.Data_2_In ? 2'd1 : 2'd0;
    valid_d = bus.Enable_In & (bus.Data_0_In | bus.Data_1_In | bus.Data_2_In | bus.Data_3_In);
    encoded_value_d = valid_d ? code : encoded_value_q;
  end
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      valid_q <= 1'b0;
      encoded_value_q <= 2'd0;
    end else begin
      valid_q <= valid_d;
      encoded_value_q <= encoded_value_d;
    end
  end
  assign bus.Encoded_Value_Out = valid_q ? encoded_value_q : 2'bzz;
`ifdef LPE_VALID_OUT_EN
  assign bus.Valid_Out = valid_q;
`endif
endmodule

// File: tb/tb_low_priority_encoder_4_2.sv
// tb_low_priority_encoder_4_2: directed and random checks against a one-cycle-delayed priority model
module tb_low_priority_encoder_4_2;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails = 0;
  low_priority_encoder_4_2_if bus_if ();
  low_priority_encoder_4_2 dut (
    .Clock_In (clk),
    .Reset_In (rst),
    .bus      (bus_if)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] model(input logic r, input logic en, input logic [3:0] d);
    if (r || !en || d == 4'd0) return 2'bzz;
    for (int i = 0; i < 4; i++)
      if (d[i]) return 2'(3 - i);
    return 2'bzz;
  endfunction
  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic en, input logic [3:0] d);
    logic [1:0] exp;
    @(negedge clk);
    rst = r;
    bus_if.Enable_In = en;
    {bus_if.Data_3_In, bus_if.Data_2_In, bus_if.Data_1_In, bus_if.Data_0_In} = d;
    exp = model(r, en, d);
    @(posedge clk);
    #1;
    check(tag, bus_if.Encoded_Value_Out, exp);
`ifdef LPE_VALID_OUT_EN
    check({tag, "_valid"}, {1'b0, bus_if.Valid_Out}, {1'b0, exp !== 2'bzz});
`endif
  endtask
  initial begin
    rst = 1'b1;
    bus_if.Enable_In = 1'b0;
    {bus_if.Data_3_In, bus_if.Data_2_In, bus_if.Data_1_In, bus_if.Data_0_In} = 4'd0;
    step("reset", 1'b1, 1'b1, 4'b1111);
    step("en_off", 1'b0, 1'b0, 4'b1111);
    step("one_d0", 1'b0, 1'b1, 4'b0001);
    step("one_d1", 1'b0, 1'b1, 4'b0010);
    step("one_d2", 1'b0, 1'b1, 4'b0100);
    step("one_d3", 1'b0, 1'b1, 4'b1000);
    step("pri_1110", 1'b0, 1'b1, 4'b1110);
    step("pri_1011", 1'b0, 1'b1, 4'b1011);
    step("none", 1'b0, 1'b1, 4'b0000);
    step("hold_pre", 1'b0, 1'b1, 4'b1000);
    step("mid_reset", 1'b1, 1'b1, 4'b1000);
    step("post_reset", 1'b0, 1'b1, 4'b1000);
    step("tog_en1", 1'b0, 1'b1, 4'b0100);
    step("tog_en0", 1'b0, 1'b0, 4'b0100);
    step("tog_en1b", 1'b0, 1'b1, 4'b0100);
    for (int i = 0; i < 20; i++)
      step($sformatf("rand%0d", i), 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
